ldl_reconstruct: RTL and testbench

Sequential recomposition block that takes the unit-lower-triangular factor L and the diagonal D from the LDL factorizer and rebuilds the symmetric matrix A = L·D·Lᵀ. It is used as the inverse path of the factorizer: for self-check of factorization results and for regenerating A from stored L/D in the matrix-inversion flow. It uses one multiply-accumulate step per cycle under a small FSM with a start/busy/done handshake. Its flattened port layout matches the factorizer's `L_out` and `D_out`.

---
 rtl/ldl_reconstruct.sv | 121 ++++++++++++
 tb/tb_ldl_reconstruct.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ldl_reconstruct.sv
// Rebuilds the symmetric matrix A = L*D*L^T from a unit-lower-triangular L and diagonal D,
// one multiply-accumulate term per clock, under a start/busy/done handshake.
module ldl_reconstruct #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W*N*N-1:0] L_in,
  input  logic [W*N-1:0]   D_in,
  output logic             busy,
  output logic             done,
  output logic [W*N*N-1:0] matrix_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [W-1:0]     l_eff  [N][N];
  logic [W-1:0]     l_reg  [N][N];
  logic [W-1:0]     d_reg  [N];
  logic [W-1:0]     r_reg  [N][N];
  logic [W*N*N-1:0] r_flat;
  logic [W*N*N-1:0] final_flat;
  logic [W-1:0]     acc;
  logic [W-1:0]     term;
  logic [W-1:0]     acc_next;
  logic [IW-1:0]    i_idx;
  logic [IW-1:0]    j_idx;
  logic [IW-1:0]    k_idx;

  // The unit diagonal and the zero upper triangle are imposed once at latch time,
  // so the datapath never has to look at the input's diagonal or upper entries.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign l_eff[gi][gj] = (gi == gj) ? W'(1) :
                             (gj > gi)  ? '0    : L_in[W*(gi*N+gj) +: W];
      assign r_flat[W*(gi*N+gj) +: W] = r_reg[gi][gj];
    end
  end

  assign term     = l_reg[i_idx][k_idx] * d_reg[k_idx] * l_reg[j_idx][k_idx];
  assign acc_next = acc + term;

  // The last term only ever lands on the bottom-right element, so splice it in directly.
  always_comb begin
    final_flat = r_flat;
    final_flat[W*(N*N-1) +: W] = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      matrix_out <= '0;
      acc        <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      k_idx      <= '0;
      for (int a = 0; a < N; a++) begin
        d_reg[a] <= '0;
        for (int b = 0; b < N; b++) begin
          l_reg[a][b] <= '0;
          r_reg[a][b] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int a = 0; a < N; a++) begin
              d_reg[a] <= D_in[W*a +: W];
              for (int b = 0; b < N; b++) begin
                l_reg[a][b] <= l_eff[a][b];
              end
            end
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (k_idx == j_idx) begin
            r_reg[i_idx][j_idx] <= acc_next;
            r_reg[j_idx][i_idx] <= acc_next;
            acc   <= '0;
            k_idx <= '0;
            if (j_idx == i_idx) begin
              j_idx <= '0;
              if (i_idx == LAST) begin
                i_idx      <= '0;
                matrix_out <= final_flat;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= IDLE;
              end else begin
                i_idx <= i_idx + 1'b1;
              end
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            acc   <= acc_next;
            k_idx <= k_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldl_reconstruct.sv
// Self-checking bench: directed N=3 cases plus random N=1/N=4 runs against a
// full matrix-product reference model.
module tb_ldl_reconstruct;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  int           sel = 3;
  logic [127:0] l_all = '0;
  logic [31:0]  d_all = '0;

  logic        busy1, done1, busy3, done3, busy4, done4;
  logic [7:0]  m1;
  logic [71:0] m3;
  logic [127:0] m4;
  logic        busy_s, done_s;
  logic [127:0] mat_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ldl_reconstruct #(.N(1), .W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .L_in(l_all[7:0]), .D_in(d_all[7:0]),
    .busy(busy1), .done(done1), .matrix_out(m1));
  ldl_reconstruct #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start && sel == 3), .L_in(l_all[71:0]), .D_in(d_all[23:0]),
    .busy(busy3), .done(done3), .matrix_out(m3));
  ldl_reconstruct #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start && sel == 4), .L_in(l_all), .D_in(d_all),
    .busy(busy4), .done(done4), .matrix_out(m4));

  always_comb begin
    busy_s = (sel == 1) ? busy1 : (sel == 4) ? busy4 : busy3;
    done_s = (sel == 1) ? done1 : (sel == 4) ? done4 : done3;
    mat_s  = (sel == 1) ? {120'b0, m1} : (sel == 4) ? m4 : {56'b0, m3};
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A = L*D*L^T as a plain full triple sum over a masked L, reduced mod 256.
  function automatic logic [127:0] model(input int n, input logic [127:0] l, input logic [31:0] d);
    logic [127:0] res;
    int lm [4][4];
    int sum;
    res = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        lm[i][j] = (i == j) ? 1 : (j > i) ? 0 : int'(l[8*(i*n+j) +: 8]);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        sum = 0;
        for (int k = 0; k < n; k++)
          sum += lm[i][k] * int'(d[8*k +: 8]) * lm[j][k];
        res[8*(i*n+j) +: 8] = 8'(sum % 256);
      end
    return res;
  endfunction

  task automatic run(input int n, input logic [127:0] l, input logic [31:0] d,
                     input logic [127:0] exp, input string tag);
    int cyc;
    logic [127:0] tr;
    sel = n; l_all = l; d_all = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy_s && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, " latency"}, 128'(cyc), 128'(n*(n+1)*(n+2)/6));
    check({tag, " done"}, 128'(done_s), 128'd1);
    check({tag, " matrix"}, mat_s, exp);
    tr = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        tr[8*(i*n+j) +: 8] = mat_s[8*(j*n+i) +: 8];
    check({tag, " symmetric"}, tr, mat_s);
    @(negedge clk);
    check({tag, " done_pulse"}, 128'(done_s), 128'd0);
  endtask

  localparam logic [71:0] L_BASIC = 72'h01_04_03_00_01_02_00_00_01;
  localparam logic [71:0] L_IGN   = 72'h00_04_03_FF_00_02_FF_FF_00;
  localparam logic [23:0] D_BASIC = 24'h05_03_02;
  localparam logic [71:0] A_BASIC = 72'h47_18_06_18_0B_04_06_04_02;
  localparam logic [71:0] L_WRAP  = 72'h01_00_00_00_01_02_00_00_01;
  localparam logic [23:0] D_WRAP  = 24'h07_01_C8;
  localparam logic [71:0] A_WRAP  = 72'h07_00_00_00_21_90_00_90_C8;

  initial begin
    logic [127:0] lr;
    logic [31:0]  dr;
    int dt [$];
    int seen;
    int cnt;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy3", 128'(busy3), 128'd0);
    check("reset done3", 128'(done3), 128'd0);
    check("reset matrix3", 128'(m3), 128'd0);
    check("reset matrix4", m4, 128'd0);

    run(3, 128'(L_BASIC), 32'(D_BASIC), 128'(A_BASIC), "basic");
    run(3, 128'(L_IGN), 32'(D_BASIC), 128'(A_BASIC), "ignored");
    run(3, 128'(L_WRAP), 32'(D_WRAP), 128'(A_WRAP), "wrap");

    // Start held high; L changes mid-computation and must only affect the next matrix.
    lr = {$urandom, $urandom, $urandom, $urandom};
    sel = 3; l_all = 128'(L_BASIC); d_all = 32'(D_BASIC); start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      if (c == 4) l_all = {56'b0, lr[71:0]};
      if (done_s) begin
        dt.push_back(c);
        check("handshake matrix", mat_s,
              (dt.size() == 1) ? 128'(A_BASIC) : model(3, {56'b0, lr[71:0]}, 32'(D_BASIC)));
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("handshake done count", 128'(dt.size()), 128'd2);
    check("handshake first done", 128'((dt.size() > 0) ? dt[0] : -1), 128'd11);
    check("handshake period", 128'((dt.size() > 1) ? dt[1] - dt[0] : -1), 128'd11);
    cnt = 0;
    while ((busy_s || done_s) && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end

    // Reset mid-computation aborts with no done and clears the output.
    sel = 3; l_all = 128'(L_BASIC); d_all = 32'(D_BASIC); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (4) begin
      if (done_s) seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 128'(busy_s), 128'd0);
    check("abort matrix", mat_s, 128'd0);
    repeat (15) begin
      if (done_s) seen++;
      @(negedge clk);
    end
    check("abort no done", 128'(seen), 128'd0);
    run(3, 128'(L_BASIC), 32'(D_BASIC), 128'(A_BASIC), "after abort");

    for (int t = 0; t < 4; t++) begin
      lr = {$urandom, $urandom, $urandom, $urandom};
      dr = $urandom;
      run(1, lr, dr, model(1, lr, dr), $sformatf("rand n1 #%0d", t));
      run(4, lr, dr, model(4, lr, dr), $sformatf("rand n4 #%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
